// File: rtl/shift_add_multiplier_4bit_pkg.sv
// Shared definitions for the 4x4 shift-add multiplier: widths, iteration count
// and state encoding.
package shift_add_multiplier_4bit_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;
  localparam int N_ITER = 4;

  localparam logic [1:0] LAST_ITER = 2'(N_ITER - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_4bit_adder.sv
// 4-bit ripple-carry adder used for the partial-product accumulate.
module full_adder_4bit (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]       = in1[i] ^ in2[i] ^ carry[i];
      carry[i + 1] = (in1[i] & in2[i]) | (carry[i] & (in1[i] ^ in2[i]));
    end
    cout = carry[4];
  end

endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned multiplier: one add-and-shift per clock, fixed
// latency of four CALC edges, product held until the next completion.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// CALC  | four add/shift iterations on acc, busy high
// DONE  | one-cycle done pulse, then back to IDLE
module shift_add_multiplier_4bit
  import shift_add_multiplier_4bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   in1,
  input  logic [OP_W-1:0]   in2,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     mcand_q, mcand_d;
  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [1:0]          count_q, count_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [PROD_W-1:0]   product_q, product_d;

  logic [OP_W-1:0]     addend;
  logic [OP_W-1:0]     sum;
  logic                carry;
  logic [PROD_W-1:0]   acc_shift;

  assign addend = acc_q[0] ? mcand_q : '0;

  full_adder_4bit u_adder (
    .in1  (acc_q[7:4]),
    .in2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Carry lands in acc[7], so the 8-bit accumulator can never overflow.
  assign acc_shift = {carry, sum, acc_q[3:1]};

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = done_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = in1;
          acc_d   = {4'b0000, in2};
          count_d = 2'd0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d   = acc_shift;
        count_d = count_q + 2'd1;
        if (count_q == LAST_ITER) begin
          product_d = acc_shift;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
// Directed and exhaustive checks for the shift-add multiplier.
module tb_shift_add_multiplier_4bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] in1;
  logic [3:0] in2;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] prev_product;

  always #5 clk = ~clk;

  shift_add_multiplier_4bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // hold=1 keeps start high with 7x7 on the operands through CALC and DONE.
  task automatic mult(input logic [3:0] a, input logic [3:0] b, input bit hold);
    logic [7:0] exp_p;
    int         lat;
    bit         seen;
    exp_p = {4'b0000, a} * {4'b0000, b};
    @(negedge clk);
    start = 1'b1;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    check("busy_after_accept", 16'(busy), 16'd1);
    if (hold) begin
      in1 = 4'd7;
      in2 = 4'd7;
    end else begin
      start = 1'b0;
      in1   = ~a;
      in2   = b ^ 4'h5;
    end
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        check("busy_in_calc", 16'(busy), 16'd1);
        check("product_held", 16'(product), 16'(prev_product));
      end
    end
    check("done_seen", 16'(seen), 16'd1);
    check("latency", 16'(lat), 16'd4);
    check("product", 16'(product), 16'(exp_p));
    check("busy_at_done", 16'(busy), 16'd0);
    prev_product = exp_p;
    @(posedge clk);
    #1;
    check("done_one_cycle", 16'(done), 16'd0);
    check("product_stable", 16'(product), 16'(prev_product));
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    in1          = 4'd0;
    in2          = 4'd0;
    prev_product = 8'h00;
    #12;
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    check("reset_product", 16'(product), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    mult(4'd15, 4'd15, 1'b0);
    mult(4'd9, 4'd6, 1'b0);
    mult(4'd0, 4'd13, 1'b0);
    mult(4'd13, 4'd0, 1'b0);
    mult(4'd3, 4'd5, 1'b1);
    mult(4'd7, 4'd7, 1'b0);

    // Abort 11x11 with a reset pulse during its second CALC cycle.
    @(negedge clk);
    start = 1'b1;
    in1   = 4'd11;
    in2   = 4'd11;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    check("abort_product", 16'(product), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    prev_product = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_done_after_abort", 16'(done), 16'd0);
    end
    mult(4'd11, 4'd11, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mult(4'(a), 4'(b), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier_4bit.md
SHIFT_ADD_MULTIPLIER_4BIT -- requirements
Module: shift_add_multiplier_4bit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 4 bits, product width at 8 bits.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-006 in1  input  4  multiplicand, unsigned; sampled with an accepted start.
REQ-007 in2  input  4  multiplier, unsigned; sampled with an accepted start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse when product becomes valid.
REQ-010 product  output  8  unsigned in1*in2, held until the next completion.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-012 IDLE with start=1 at edge E0: mcand<=in1, acc<={4'b0,in2}, count<=0, busy<=1, state<=CALC.
REQ-013 IDLE with start=0: state and all registers SHALL hold.
REQ-014 Each CALC edge: addend = acc[0] ? mcand : 4'b0; {c,s} = acc[7:4] + addend + 0 via the 4-bit adder; acc<={c,s,acc[3:1]}; count<=count+1.
REQ-015 CALC SHALL run exactly 4 edges (E1..E4); at E4: product<=final acc, done<=1, busy<=0, state<=DONE.
REQ-016 DONE at E5: done<=0, state<=IDLE; done SHALL be high for exactly one cycle.
REQ-017 Latency SHALL be fixed: done high in the cycle following E4, i.e. 4 clocks after the edge that accepted start, independent of operand values.
REQ-018 start asserted in CALC or DONE SHALL be ignored (not queued); in1/in2 changes outside E0 SHALL not affect the result.
REQ-019 The earliest next accepted start SHALL be at E6 (first IDLE edge); throughput is one multiply per 6 cycles.
REQ-020 product SHALL change only at the completing edge (E4) or on reset; it SHALL never show intermediate acc values.
REQ-021 The adder carry-in SHALL be tied to 0; the carry-out SHALL be captured into acc[7] every iteration, so no overflow is possible (max 15*15=225).
REQ-022 count SHALL be 2 bits (3 if simpler for compare); wrap of count SHALL NOT occur because CALC exits at the 4th iteration.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, busy=0, done=0, product=8'h00, acc=0, mcand=0, count=0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse; the first start after rst_n release SHALL operate normally.
REQ-025 Reset release SHALL take effect synchronously from the next rising clk edge; start sampled on that edge SHALL be accepted.

Structure
REQ-026 A shared include file mult_defs.vh SHALL hold the state-encoding localparams (IDLE, CALC, DONE), operand width (4) and iteration count (4).
REQ-027 The addition SHALL be performed by one instance of the existing full_adder_4bit sub-module (in1=acc[7:4], in2=addend, cin=0); no behavioural "+" for the datapath add.
REQ-028 All registers SHALL live in a single clocked process with asynchronous reset; next-state/addend logic combinational.

Verification
REQ-029 rst_n low then high, start with in1=15, in2=15 at E0 -> busy high E0..E4, done pulse after E4, product=8'hE1 (225).
REQ-030 in1=9, in2=6 -> product=8'h36 (54); in1=0, in2=13 -> product=8'h00; in1=13, in2=0 -> product=8'h00.
REQ-031 start with 3x5, then start held high with in1=7, in2=7 during CALC and DONE -> product=8'h0F, single done pulse; 7x7 accepted at E6 -> product=8'h31 after its own done.
REQ-032 rst_n pulsed low during the 2nd CALC cycle of 11x11 -> product=0, busy=0, no done; subsequent 11x11 -> product=8'h79 (121).
REQ-033 Exhaustive sweep of all 256 operand pairs, back-to-back starts -> product equals in1*in2 every time, done exactly once per start, latency always 4 clocks.
